// File: rtl/muldiv_sched_pkg.sv
// Shared definitions for the RV32M multiply/divide scheduler: funct3 codes and FSM states.
package muldiv_sched_pkg;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN0 = 2'd1,
      MD_RUN1 = 2'd2,
      MD_DONE = 2'd3
   } md_state_e;

   function automatic logic is_mul(input logic [2:0] op);
      return ~op[2];
   endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes with sign fix-up.
// MULDIV_FAST_MUL_EN: multiplies finish on the start edge with a full-width multiplier.
module muldiv_core
   import muldiv_sched_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            busy_o,
   output logic [XLEN-1:0] result_o
);

   logic [CNT_W-1:0]  r_cnt;
   logic [2:0]        r_op;
   logic              r_neg;
   logic [XLEN:0]     r_hi;
   logic [XLEN-1:0]   r_lo;
   logic [XLEN-1:0]   r_m;

   logic              w_a_sgn, w_b_sgn, w_a_neg, w_b_neg, w_neg;
   logic [XLEN-1:0]   w_a_mag, w_b_mag;
   logic [2*XLEN:0]   w_ld;
   logic [CNT_W-1:0]  w_ld_cnt;
   logic [2*XLEN-1:0] w_prod, w_sprod;
   logic [XLEN-1:0]   w_qr, w_sqr;

   // One iteration on {hi, lo}: multiply adds m on lo[0] and shifts right,
   // divide shifts left and keeps the trial subtract when it does not borrow.
   function automatic logic [2*XLEN:0] step(input logic div, input logic [XLEN:0] hi,
                                            input logic [XLEN-1:0] lo, input logic [XLEN-1:0] m);
      logic [XLEN:0] sum, sh, trial;
      sum   = hi + (lo[0] ? {1'b0, m} : '0);
      sh    = {hi[XLEN-1:0], lo[XLEN-1]};
      trial = sh - {1'b0, m};
      if (!div)
         return {1'b0, sum[XLEN:1], sum[0], lo[XLEN-1:1]};
      return {(trial[XLEN] ? sh : trial), lo[XLEN-2:0], ~trial[XLEN]};
   endfunction

   assign w_a_sgn = (op_i == F3_MUL) | (op_i == F3_MULH) | (op_i == F3_MULHSU) |
                    (op_i == F3_DIV) | (op_i == F3_REM);
   assign w_b_sgn = (op_i == F3_MUL) | (op_i == F3_MULH) | (op_i == F3_DIV) | (op_i == F3_REM);
   assign w_a_neg = w_a_sgn & a_i[XLEN-1];
   assign w_b_neg = w_b_sgn & b_i[XLEN-1];
   assign w_a_mag = w_a_neg ? -a_i : a_i;
   assign w_b_mag = w_b_neg ? -b_i : b_i;
   // Divide-by-zero quotient stays all-ones, so it is never negated.
   assign w_neg   = is_mul(op_i) ? (w_a_neg ^ w_b_neg) :
                    op_i[1]      ? w_a_neg : ((w_a_neg ^ w_b_neg) & (|b_i));

   // The start edge already performs the first iteration.
   always_comb begin
      w_ld     = step(op_i[2], '0, w_a_mag, w_b_mag);
      w_ld_cnt = CNT_W'(XLEN - 1);
`ifdef MULDIV_FAST_MUL_EN
      if (is_mul(op_i)) begin
         w_ld     = {1'b0, (2*XLEN)'(w_a_mag) * (2*XLEN)'(w_b_mag)};
         w_ld_cnt = '0;
      end
`endif
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt <= '0;
         r_op  <= '0;
         r_neg <= 1'b0;
         r_hi  <= '0;
         r_lo  <= '0;
         r_m   <= '0;
      end else if (start_i) begin
         r_op          <= op_i;
         r_neg         <= w_neg;
         r_m           <= w_b_mag;
         {r_hi, r_lo}  <= w_ld;
         r_cnt         <= w_ld_cnt;
      end else if (r_cnt != '0) begin
         {r_hi, r_lo}  <= step(r_op[2], r_hi, r_lo, r_m);
         r_cnt         <= r_cnt - 1'b1;
      end
   end

   assign w_prod   = {r_hi[XLEN-1:0], r_lo};
   assign w_sprod  = r_neg ? -w_prod : w_prod;
   assign w_qr     = r_op[1] ? r_hi[XLEN-1:0] : r_lo;
   assign w_sqr    = r_neg ? -w_qr : w_qr;
   assign busy_o   = (r_cnt != '0);
   assign result_o = r_op[2]            ? w_sqr :
                     (r_op[1:0] == 2'b00) ? w_sprod[XLEN-1:0] : w_sprod[2*XLEN-1:XLEN];

endmodule

// File: rtl/muldiv_sched.sv
// Shares one muldiv_core between execute slots 0 and 1; slot 0 is served first.
// MULDIV_FAST_MUL_EN: multiplies hold the RUN state for a single counted cycle.
module muldiv_sched
   import muldiv_sched_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req0_i,
   input  logic [2:0]      op0_i,
   input  logic [XLEN-1:0] a0_i,
   input  logic [XLEN-1:0] b0_i,
   input  logic            req1_i,
   input  logic [2:0]      op1_i,
   input  logic [XLEN-1:0] a1_i,
   input  logic [XLEN-1:0] b1_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic [XLEN-1:0] res0_o,
   output logic [XLEN-1:0] res1_o,
   output logic            done_o
);

   md_state_e         r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_ld;
   logic [XLEN-1:0]   r_res0, r_res1;

   logic              w_load0, w_load1, w_hand, w_lat0, w_lat1, w_done, w_stall;
   logic              w_start, w_busy, w_last;
   logic [2:0]        w_op;
   logic [XLEN-1:0]   w_a, w_b, w_result;

   assign w_start = w_load0 | w_load1;
   assign w_op    = w_load1 ? op1_i : op0_i;
   assign w_a     = w_load1 ? a1_i  : a0_i;
   assign w_b     = w_load1 ? b1_i  : b0_i;
   assign w_last  = (r_cnt == '0) && !w_busy;

   muldiv_core #(.XLEN(XLEN), .CNT_W(CNT_W)) u_core (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .start_i  (w_start),
      .op_i     (w_op),
      .a_i      (w_a),
      .b_i      (w_b),
      .busy_o   (w_busy),
      .result_o (w_result)
   );

   // Slot 1 starts on the edge that retires slot 0, so its count is one shorter.
   always_comb begin
      w_cnt_ld = CNT_W'(XLEN);
`ifdef MULDIV_FAST_MUL_EN
      if (is_mul(w_op)) w_cnt_ld = CNT_W'(1);
`endif
      if (w_hand) w_cnt_ld = w_cnt_ld - 1'b1;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load0     = 1'b0;
      w_load1     = 1'b0;
      w_hand      = 1'b0;
      w_lat0      = 1'b0;
      w_lat1      = 1'b0;
      w_done      = 1'b0;
      w_stall     = 1'b0;
      case (r_state)
         MD_IDLE: begin
            w_stall = req0_i | req1_i;
            if (req0_i) begin
               w_load0     = 1'b1;
               w_state_nxt = MD_RUN0;
            end else if (req1_i) begin
               w_load1     = 1'b1;
               w_state_nxt = MD_RUN1;
            end
         end
         MD_RUN0: begin
            w_stall = 1'b1;
            if (w_last) begin
               w_lat0 = 1'b1;
               if (req1_i) begin
                  w_load1     = 1'b1;
                  w_hand      = 1'b1;
                  w_state_nxt = MD_RUN1;
               end else begin
                  w_state_nxt = MD_DONE;
               end
            end
         end
         MD_RUN1: begin
            w_stall = 1'b1;
            if (w_last) begin
               w_lat1      = 1'b1;
               w_state_nxt = MD_DONE;
            end
         end
         MD_DONE: begin
            w_done      = 1'b1;
            w_state_nxt = MD_IDLE;
         end
         default: w_state_nxt = MD_IDLE;
      endcase
      // A flush beats completion landing in the same cycle.
      if (flush_i) begin
         w_state_nxt = MD_IDLE;
         w_load0     = 1'b0;
         w_load1     = 1'b0;
         w_hand      = 1'b0;
         w_lat0      = 1'b0;
         w_lat1      = 1'b0;
         w_done      = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= MD_IDLE;
         r_cnt   <= '0;
         r_res0  <= '0;
         r_res1  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_start)            r_cnt <= w_cnt_ld;
         else if (flush_i)       r_cnt <= '0;
         else if (r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
         if (w_lat0) r_res0 <= w_result;
         if (w_lat1) r_res1 <= w_result;
      end
   end

   assign stall_o = w_stall;
   assign done_o  = w_done;
   assign res0_o  = r_res0;
   assign res1_o  = r_res1;

endmodule

// File: tb/tb_muldiv_sched.sv
// Randomized self-checking bench for muldiv_sched against a 64-bit arithmetic reference model.
module tb_muldiv_sched;
   import muldiv_sched_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i, req0_i, req1_i, flush_i;
   logic [2:0]  op0_i, op1_i;
   logic [31:0] a0_i, b0_i, a1_i, b1_i;
   logic        stall_o, done_o;
   logic [31:0] res0_o, res1_o;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_r0 = '0;
   logic [31:0] exp_r1 = '0;

   always #5 clk_i = ~clk_i;

   muldiv_sched dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req0_i(req0_i), .op0_i(op0_i), .a0_i(a0_i), .b0_i(b0_i),
      .req1_i(req1_i), .op1_i(op1_i), .a1_i(a1_i), .b1_i(b1_i),
      .flush_i(flush_i), .stall_o(stall_o),
      .res0_o(res0_o), .res1_o(res1_o), .done_o(done_o)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, ua, ub, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      p  = 0;
      case (op)
         F3_MUL:    begin p = sa * sb; return p[31:0];  end
         F3_MULH:   begin p = sa * sb; return p[63:32]; end
         F3_MULHSU: begin p = sa * ub; return p[63:32]; end
         F3_MULHU:  begin p = ua * ub; return p[63:32]; end
         F3_DIV: begin
            if (b == 0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
            p = sa / sb; return p[31:0];
         end
         F3_REM: begin
            if (b == 0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
            p = sa % sb; return p[31:0];
         end
         F3_DIVU: begin
            if (b == 0) return 32'hFFFFFFFF;
            p = ua / ub; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            p = ua % ub; return p[31:0];
         end
      endcase
   endfunction

   // Cycles from the load edge to the done cycle for one op on its own.
   function automatic int tcost(input logic [2:0] op);
`ifdef MULDIV_FAST_MUL_EN
      if (!op[2]) return 2;
`endif
      return 33;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'h7FFFFFFF;
         default: return $urandom();
      endcase
   endfunction

   task automatic drive(input logic r0, input logic [2:0] o0, input logic [31:0] x0, input logic [31:0] y0,
                        input logic r1, input logic [2:0] o1, input logic [31:0] x1, input logic [31:0] y1);
      req0_i = r0; op0_i = o0; a0_i = x0; b0_i = y0;
      req1_i = r1; op1_i = o1; a1_i = x1; b1_i = y1;
   endtask

   task automatic run_txn(input logic r0, input logic [2:0] o0, input logic [31:0] x0, input logic [31:0] y0,
                          input logic r1, input logic [2:0] o1, input logic [31:0] x1, input logic [31:0] y1);
      logic [31:0] e0, e1;
      int lat, n;
      bit stall_ok;
      e0  = r0 ? model(o0, x0, y0) : exp_r0;
      e1  = r1 ? model(o1, x1, y1) : exp_r1;
      lat = r0 ? tcost(o0) + (r1 ? tcost(o1) - 1 : 0) : tcost(o1);
      drive(r0, o0, x0, y0, r1, o1, x1, y1);
      #1 chk("stall_req", stall_o, 1);
      @(posedge clk_i);
      n = 0;
      stall_ok = 1;
      while (n < lat + 3) begin
         @(negedge clk_i);
         if (done_o) break;
         if (stall_o !== 1'b1) stall_ok = 0;
         n++;
      end
      chk("stall_run", stall_ok, 1);
      chk("done_lat", n, lat);
      chk("stall_done", stall_o, 0);
      chk("res0", res0_o, e0);
      chk("res1", res1_o, e1);
      exp_r0 = e0;
      exp_r1 = e1;
      req0_i = 0; req1_i = 0;
      @(posedge clk_i); @(negedge clk_i);
      chk("done_pulse", done_o, 0);
      chk("stall_idle", stall_o, 0);
   endtask

   // Dual request killed 'at' cycles after the load edge (before completion).
   task automatic run_flush(input logic [2:0] o0, input logic [31:0] x0, input logic [31:0] y0,
                            input logic [2:0] o1, input logic [31:0] x1, input logic [31:0] y1,
                            input int at);
      logic [31:0] e0;
      bit seen;
      e0 = (at >= tcost(o0)) ? model(o0, x0, y0) : exp_r0;
      drive(1, o0, x0, y0, 1, o1, x1, y1);
      @(posedge clk_i);
      seen = 0;
      repeat (at + 1) begin
         @(negedge clk_i);
         if (done_o) seen = 1;
      end
      flush_i = 1; req0_i = 0; req1_i = 0;
      @(posedge clk_i); @(negedge clk_i);
      flush_i = 0;
      chk("fl_nodone", seen | done_o, 0);
      chk("fl_stall", stall_o, 0);
      chk("fl_res0", res0_o, e0);
      chk("fl_res1", res1_o, exp_r1);
      exp_r0 = e0;
      @(posedge clk_i); @(negedge clk_i);
      chk("fl_idle_done", done_o, 0);
   endtask

   task automatic run_reset(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int at);
      drive(1, o, x, y, 0, F3_MUL, 0, 0);
      @(posedge clk_i);
      repeat (at + 1) @(negedge clk_i);
      rst_i = 1; req0_i = 0;
      @(posedge clk_i); @(negedge clk_i);
      rst_i = 0;
      chk("rst_res0", res0_o, 0);
      chk("rst_res1", res1_o, 0);
      chk("rst_stall", stall_o, 0);
      chk("rst_done", done_o, 0);
      exp_r0 = '0;
      exp_r1 = '0;
   endtask

   initial begin
      logic        r0, r1;
      logic [2:0]  o0, o1;
      logic [31:0] x0, y0, x1, y1;
      rst_i = 1; flush_i = 0;
      drive(0, F3_MUL, 0, 0, 0, F3_MUL, 0, 0);
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 0;
      chk("reset_stall", stall_o, 0);
      chk("reset_done", done_o, 0);
      chk("reset_res0", res0_o, 0);
      chk("reset_res1", res1_o, 0);

      run_txn(1, F3_MUL, 32'd7, 32'hFFFFFFFD, 0, F3_MUL, 0, 0);
      run_txn(1, F3_DIV, 32'd100, 32'd7, 1, F3_REMU, 32'hFFFFFFFF, 32'd10);
      run_txn(1, F3_DIV, 32'h80000000, 32'hFFFFFFFF, 1, F3_REM, 32'h80000000, 32'hFFFFFFFF);
      run_txn(1, F3_DIVU, 32'd5, 32'd0, 1, F3_REMU, 32'd5, 32'd0);
      run_txn(1, F3_DIV, 32'hFFFFFFF9, 32'd0, 1, F3_REM, 32'hFFFFFFF9, 32'd2);
      run_txn(1, F3_MULH, 32'h80000000, 32'h80000000, 1, F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      run_txn(0, F3_MUL, 0, 0, 1, F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      run_txn(1, F3_MUL, 32'd6, 32'd7, 0, F3_MUL, 0, 0);
      run_txn(1, F3_DIVU, 32'd42, 32'd6, 0, F3_MUL, 0, 0);
      run_txn(1, F3_MUL, 32'd6, 32'd7, 1, F3_DIVU, 32'd42, 32'd6);

      run_flush(F3_DIV, 32'd1000, 32'd3, F3_REMU, 32'hDEADBEEF, 32'd77, tcost(F3_DIV) + 5);
      run_flush(F3_DIVU, 32'd99, 32'd4, F3_REM, 32'hFFFFFF00, 32'd9,
                tcost(F3_DIVU) + tcost(F3_REM) - 2);
      run_flush(F3_REM, 32'd50, 32'd6, F3_DIV, 32'd8, 32'd2, tcost(F3_REM) - 1);
      run_reset(F3_DIVU, 32'd12345, 32'd11, 10);
      run_txn(1, F3_REM, 32'hFFFFFF9C, 32'd7, 0, F3_MUL, 0, 0);

      for (int i = 0; i < 30; i++) begin
         r0 = 1'($urandom_range(0, 1));
         r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
         o0 = 3'($urandom_range(0, 7));
         o1 = 3'($urandom_range(0, 7));
         x0 = pick(); y0 = pick(); x1 = pick(); y1 = pick();
         if (r0 && r1 && $urandom_range(0, 4) == 0)
            run_flush(o0, x0, y0, o1, x1, y1, $urandom_range(0, tcost(o0) + tcost(o1) - 2));
         else
            run_txn(r0, o0, x0, y0, r1, o1, x1, y1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
